// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex-to-segment table and the dwell-length helper.
package seg7_pkg;

  // Bit positions inside a 7-bit segment word (gfedcba, a in bit 0).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high gfedcba patterns for nibble values 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Number of clock cycles each digit is held for.
  function automatic int dwell_cycles(input int clk_hz, input int refresh_hz);
    return clk_hz / refresh_hz;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit to 7-segment decoder (active-high gfedcba output).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Table lookup, copied segment by segment a..g.
  always_comb begin
    o_seg = '0;
    for (int s = SEG_A; s <= SEG_G; s++) begin
      o_seg[s] = HEX_SEG[i_nib][s];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. A dwell counter and a
// digit index scan the digits; each dwell opens with a blanking gap. New data
// is held in a shadow copy and only becomes visible at a frame boundary.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int DWELL = dwell_cycles(CLK_HZ, REFRESH_HZ);
  localparam int CNT_W = $clog2(DWELL);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic             INV       = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_dig_sh, r_dig_act;
  logic [NUM_DIGITS-1:0]   r_dp_sh, r_dp_act;
  logic [NUM_DIGITS-1:0]   r_blank_sh, r_blank_act;
  logic                    r_lz_act;
  logic                    r_pending;
  logic [NUM_DIGITS-1:0]   r_an_p1;
  logic [6:0]              r_seg_p1;
  logic                    r_dp_p1;

  logic                    w_wrap, w_frame, w_blank_phase;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic                    w_zero_run;
  logic [3:0]              w_nib;
  logic                    w_dp_sel, w_blank_sel, w_supp_sel;
  logic [6:0]              w_dec;
  logic [NUM_DIGITS-1:0]   w_an_on;
  logic [6:0]              w_seg_on;
  logic                    w_dp_on;

  assign w_wrap        = (r_cnt == CNT_LAST);
  assign w_frame       = w_wrap && (r_idx == IDX_LAST);
  assign w_blank_phase = (r_cnt < CNT_BLANK);

  // Dwell prescaler and digit index; index steps once per dwell wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow capture and frame-boundary commit; a load landing on the boundary
  // bypasses the shadow and goes straight to the active copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dig_sh    <= '0;
      r_dp_sh     <= '0;
      r_blank_sh  <= '0;
      r_dig_act   <= '0;
      r_dp_act    <= '0;
      r_blank_act <= '0;
      r_lz_act    <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      if (load) begin
        r_dig_sh   <= digits_in;
        r_dp_sh    <= dp_in;
        r_blank_sh <= blank_in;
      end
      if (w_frame) begin
        r_pending <= 1'b0;
        r_lz_act  <= lz_suppress;
        if (load) begin
          r_dig_act   <= digits_in;
          r_dp_act    <= dp_in;
          r_blank_act <= blank_in;
        end else if (r_pending) begin
          r_dig_act   <= r_dig_sh;
          r_dp_act    <= r_dp_sh;
          r_blank_act <= r_blank_sh;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibbles stay zero.
  always_comb begin
    w_lz_mask  = '0;
    w_zero_run = r_lz_act;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run   = w_zero_run && (r_dig_act[i*4 +: 4] == 4'h0);
      w_lz_mask[i] = w_zero_run;
    end
  end

  // Pick out the nibble and flags of the digit currently being scanned.
  always_comb begin
    w_nib       = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    w_supp_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_dig_act[i*4 +: 4];
        w_dp_sel    = r_dp_act[i];
        w_blank_sel = r_blank_act[i];
        w_supp_sel  = w_lz_mask[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Active-high pin values before polarity; everything dark in the gap.
  always_comb begin
    w_an_on  = w_blank_phase ? '0 : (NUM_DIGITS'(1) << r_idx);
    w_seg_on = (w_blank_phase || w_blank_sel || w_supp_sel) ? 7'h00 : w_dec;
    w_dp_on  = !w_blank_phase && !w_blank_sel && w_dp_sel;
  end

  // ---- stage p1: registered pins, polarity applied ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an_p1  <= {NUM_DIGITS{INV}};
      r_seg_p1 <= {7{INV}};
      r_dp_p1  <= INV;
    end else begin
      r_an_p1  <= w_an_on ^ {NUM_DIGITS{INV}};
      r_seg_p1 <= w_seg_on ^ {7{INV}};
      r_dp_p1  <= w_dp_on ^ INV;
    end
  end

  assign an         = r_an_p1;
  assign seg        = r_seg_p1;
  assign dp         = r_dp_p1;
  assign frame_done = w_frame;
  assign pending    = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, dwell 10, blanking 2, active-low pins.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int DW    = 10;
  localparam int BC    = 2;
  localparam int FRAME = DW * ND;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;

  // Reference model: time since release, displayed data, shadow data.
  int          m_t;
  logic [15:0] m_dig, m_sh_dig;
  logic [3:0]  m_dp, m_bl, m_sh_dp, m_sh_bl;
  logic        m_lz, m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done),
    .pending     (pending)
  );

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_dig = '0; m_dp = '0; m_bl = '0; m_lz = 1'b0;
    m_sh_dig = '0; m_sh_dp = '0; m_sh_bl = '0; m_pend = 1'b0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
  endtask

  // One clock edge of the model: pins show the position just left, then data commits.
  task automatic model_edge();
    int pos;
    int digit;
    logic supp;
    logic [6:0] s_on;
    pos = m_t % DW;
    digit = (m_t / DW) % ND;
    if (pos < BC) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      supp = m_lz && (digit != 0);
      for (int k = digit; k < ND; k++) if (m_dig[k*4 +: 4] != 4'h0) supp = 1'b0;
      s_on = (m_bl[digit] || supp) ? 7'h00 : hex7(m_dig[digit*4 +: 4]);
      e_an = ~(4'b0001 << digit);
      e_seg = ~s_on;
      e_dp = ~(m_dp[digit] && !m_bl[digit]);
    end
    if ((m_t % FRAME) == FRAME - 1) begin
      if (load) begin
        m_dig = digits_in; m_dp = dp_in; m_bl = blank_in;
      end else if (m_pend) begin
        m_dig = m_sh_dig; m_dp = m_sh_dp; m_bl = m_sh_bl;
      end
      m_pend = 1'b0;
      m_lz = lz_suppress;
    end else if (load) begin
      m_sh_dig = digits_in; m_sh_dp = dp_in; m_sh_bl = blank_in;
      m_pend = 1'b1;
    end
    m_t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Loads one data set, then advances until it is on screen at the start of a frame.
  task automatic load_and_align(input logic [15:0] d, input logic [3:0] p,
                                input logic [3:0] b, output bit ok);
    digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
    step();
    load = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (frame_done) begin ok = 1'b1; break; end
      step();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    int first_fd;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({an, seg, dp, frame_done, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: got %h expected %h", {an, seg, dp, frame_done, pending},
               {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    reset_n = 1'b1;
    first_fd = -1;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL reset_scan k=%0d: got %h expected %h", k, {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
      if (k <= 2) begin
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL reset_gap k=%0d: an=%b expected 1111", k, an); end
      end else if (k <= 10) begin
        checks++;
        if (an !== 4'hE || seg !== 7'b1000000) begin
          errors++; $display("FAIL reset_digit0 k=%0d: an=%b seg=%b expected 1110/1000000", k, an, seg);
        end
      end
      if (frame_done && first_fd < 0) first_fd = k;
    end
    checks++;
    if (first_fd != 39) begin errors++; $display("FAIL first_frame_done: got cycle %0d expected 39", first_fd); end
  endtask

  task automatic test_load_commit();
    bit timeout;
    logic [6:0] xt [4];
    xt = '{7'h0E, 7'h08, 7'h24, 7'h79};
    repeat (15) step();
    digits_in = 16'h12AF; load = 1'b1;
    step();
    load = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 50; k++) begin
      checks++;
      if (pending !== 1'b1) begin errors++; $display("FAIL pending_held: got %b expected 1", pending); end
      if (frame_done) begin timeout = 1'b0; break; end
      step();
    end
    checks++;
    if (timeout) begin errors++; $display("FAIL commit_timeout: no frame_done within 50 cycles"); end
    step();
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL pending_clear: got %b expected 0", pending); end
    step();
    for (int k = 0; k < FRAME; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL commit_model: got %h expected %h", {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
      for (int d = 0; d < ND; d++) if (an === ~(4'b0001 << d)) begin
        checks++;
        if (seg !== xt[d]) begin errors++; $display("FAIL commit_digit%0d: seg=%h expected %h", d, seg, xt[d]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit timeout;
    logic [6:0] xt [4];
    xt = '{7'h06, 7'h12, 7'h46, 7'h30};
    repeat (5) step();
    digits_in = 16'h1111; load = 1'b1; step(); load = 1'b0;
    repeat (3) step();
    digits_in = 16'h2222; load = 1'b1; step(); load = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (frame_done) begin timeout = 1'b0; break; end
      step();
    end
    checks++;
    if (timeout) begin errors++; $display("FAIL last_wins_timeout: no frame_done"); end
    step(); step();
    for (int k = 0; k < FRAME; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL last_wins_model: got %h expected %h", {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
      if (an !== 4'hF) begin
        checks++;
        if (seg !== 7'h24) begin errors++; $display("FAIL last_wins_seg: an=%b seg=%h expected 24", an, seg); end
      end
    end
    // Older shadow data pending, then a load exactly on the boundary.
    repeat (5) step();
    digits_in = 16'h7777; load = 1'b1; step(); load = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (frame_done) begin timeout = 1'b0; break; end
      step();
    end
    checks++;
    if (timeout) begin errors++; $display("FAIL boundary_timeout: no frame_done"); end
    digits_in = 16'h3C5E; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (pending !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL boundary_load_pending: pending=%b frame_done=%b expected 0/0", pending, frame_done);
    end
    step();
    for (int k = 0; k < FRAME; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL boundary_model: got %h expected %h", {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
      for (int d = 0; d < ND; d++) if (an === ~(4'b0001 << d)) begin
        checks++;
        if (seg !== xt[d]) begin errors++; $display("FAIL boundary_digit%0d: seg=%h expected %h", d, seg, xt[d]); end
      end
    end
  endtask

  task automatic test_lz_suppress();
    bit ok;
    logic [6:0] xt [4];
    lz_suppress = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        xt = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        load_and_align(16'h0050, 4'h0, 4'h0, ok);
      end else begin
        xt = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        load_and_align(16'h0000, 4'h0, 4'h0, ok);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL lz_align pass=%0d: no frame_done", pass); end
      for (int k = 0; k < FRAME; k++) begin
        step();
        checks++;
        if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
          errors++;
          $display("FAIL lz_model: got %h expected %h", {an, seg, dp, frame_done, pending},
                   {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
        end
        for (int d = 0; d < ND; d++) if (an === ~(4'b0001 << d)) begin
          checks++;
          if (seg !== xt[d]) begin
            errors++; $display("FAIL lz_digit%0d pass=%0d: seg=%h expected %h", d, pass, seg, xt[d]);
          end
        end
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_dp_blank();
    bit ok;
    load_and_align(16'($urandom), 4'b0100, 4'b0010, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dp_align: no frame_done"); end
    for (int k = 0; k < FRAME; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL dp_model: got %h expected %h", {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
      checks++;
      if ((dp === 1'b0) !== (an === 4'b1011)) begin
        errors++; $display("FAIL dp_digit2: dp=%b an=%b expected dp low only with an=1011", dp, an);
      end
      if (an === 4'b1101) begin
        checks++;
        if (seg !== 7'h7F || dp !== 1'b1) begin
          errors++; $display("FAIL blank_digit1: seg=%h dp=%b expected 7f/1", seg, dp);
        end
      end
    end
  endtask

  task automatic test_random();
    int gap;
    for (int it = 0; it < 10; it++) begin
      gap = $urandom_range(0, 60);
      for (int k = 0; k < gap; k++) begin
        step();
        checks++;
        if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
          errors++;
          $display("FAIL random_model it=%0d: got %h expected %h", it, {an, seg, dp, frame_done, pending},
                   {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
        end
      end
      digits_in = 16'($urandom);
      if ($urandom_range(0, 2) == 0) digits_in[15:8] = 8'h00;
      dp_in = 4'($urandom);
      blank_in = 4'($urandom) & 4'($urandom);
      lz_suppress = 1'($urandom_range(0, 1));
      load = 1'b1;
      step();
      load = 1'b0;
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL random_load it=%0d: got %h expected %h", it, {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL random_tail: got %h expected %h", {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    lz_suppress = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (an !== 4'hF) begin found = 1'b1; break; end
      step();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL async_find_drive: never saw a driven anode"); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_pins: got %h expected %h", {an, seg, dp, frame_done, pending},
               {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      checks++;
      if ({an, seg, dp, frame_done, pending} !== {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend}) begin
        errors++;
        $display("FAIL async_restart k=%0d: got %h expected %h", k, {an, seg, dp, frame_done, pending},
                 {e_an, e_seg, e_dp, ((m_t % FRAME) == FRAME - 1), m_pend});
      end
      if (k >= 3 && k <= 10) begin
        checks++;
        if (an !== 4'hE || seg !== 7'h40) begin
          errors++; $display("FAIL async_digit0 k=%0d: an=%b seg=%h expected 1110/40", k, an, seg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_back_to_back();
    test_lz_suppress();
    test_dp_blank();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a common-anode seven-segment display with NUM_DIGITS digits.
- Takes a packed hex word plus per-digit decimal-point and blank masks.
- Scans the digits with a programmable refresh rate and an inter-digit blanking gap to prevent ghosting.
- Commits new display data only at frame boundaries to prevent tearing; sits between the user datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, 1..16.
- CLK_HZ, 100000000: input clock frequency.
- REFRESH_HZ, 1000: per-digit dwell rate. DWELL = CLK_HZ/REFRESH_HZ clock cycles; DWELL must be at least 2.
- BLANK_CYCLES, 16: cycles at the start of each dwell with all anodes off. Must satisfy BLANK_CYCLES < DWELL.
- ACTIVE_LOW, 1: 1 means seg, dp and an are active-low at the pins; 0 means active-high.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe; captures digits_in, dp_in and blank_in into the shadow registers
- digits_in  in  4*NUM_DIGITS  nibble i drives digit i; digit 0 is rightmost and least significant
- dp_in  in  NUM_DIGITS  decimal point enable per digit
- blank_in  in  NUM_DIGITS  force digit i fully dark, including its dp
- lz_suppress  in  1  enable leading-zero suppression; sampled at the frame boundary with the data
- seg  out  7  segments; seg[0]=a … seg[6]=g
- dp  out  1  decimal point of the currently driven digit
- an  out  NUM_DIGITS  anode enables, one-hot when driving, all inactive during blanking
- frame_done  out  1  one-cycle pulse at the end of the last digit's dwell
- pending  out  1  shadow data loaded but not yet committed

Behaviour:
- Reset (async assert, sync release): an, seg and dp all inactive (all 1s when ACTIVE_LOW=1). Digit index, dwell counter, shadow and active registers all 0. pending=0, frame_done=0.
- Dwell counter runs 0..DWELL-1, then wraps.
  - Phase BLANK: count < BLANK_CYCLES; all anodes inactive.
  - Phase DRIVE: remaining counts; an[index] active.
- At wrap, index advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Frame boundary = wrap of the dwell counter while index == NUM_DIGITS-1.
  - frame_done pulses in that cycle.
  - Active registers update from the shadow if pending=1; pending clears.
- Load handling:
  - load=1 writes the shadow and sets pending=1.
  - A repeated load before the boundary overwrites the shadow; the last load wins.
  - load in the boundary cycle: the load data is committed directly to the active registers, pending stays 0, and the older shadow is discarded.
- Decode: standard hex, active-high gfedcba patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - All pin outputs are inverted when ACTIVE_LOW=1.
- Leading-zero suppression (lz_suppress=1): scan from digit NUM_DIGITS-1 downward; each 0 nibble is blanked until the first non-zero nibble.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its dp if dp_in is set.
- blank_in overrides everything: segments and dp both off for that digit; its anode still follows the scan.
- Pin outputs are registered. an, seg and dp change together, one cycle after the counter and index change; there are no combinational paths from inputs to pins.
- NUM_DIGITS=1: every dwell wrap is a frame boundary.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry hex-to-segment constant table
  - segment index constants SEG_A..SEG_G
  - function computing DWELL from CLK_HZ and REFRESH_HZ
- One sub-module: seg7_hex_decode, a combinational 4-bit to 7-bit decoder used on the selected digit.
- Prescaler, scan FSM, shadow/commit logic and pin registers stay in seg7_scan_driver.

Test Plan:
All scenarios use CLK_HZ=1000, REFRESH_HZ=100 (DWELL=10), BLANK_CYCLES=2, NUM_DIGITS=4, ACTIVE_LOW=1.
- Reset release with no load -> an=4'b1111 for 2 cycles, then an=4'b1110 with seg=7'b1000000 ('0') for 8 cycles. frame_done first pulses at cycle 39 after release.
- load with digits_in=16'h12AF mid-frame -> pending=1 until the boundary. Next frame shows digit0 F (~71), digit1 A (~77), digit2 2 (~5B), digit3 1 (~06); pending then 0.
- Two loads, 16'h1111 then 16'h2222, in one frame -> only 2222 is ever displayed. A load coincident with frame_done commits immediately with pending=0.
- lz_suppress=1, digits_in=16'h0050 -> digits 3 and 2 dark (seg=7F). Digit 1 shows 5 (~6D), digit 0 shows 0 (~3F). With 16'h0000, only digit 0 shows 0.
- dp_in=4'b0100, blank_in=4'b0010 -> dp=0 only while an=4'b1011. While an=4'b1101, seg=7'h7F and dp=1.
- Assert reset_n low mid-DRIVE -> an, seg and dp go inactive in the same timestep without waiting for a clock edge. After release, the scan restarts at digit 0 with display data 0.
